// File: rtl/refclk_pkg.sv
// Shared types and helpers for the refclk output-buffer sequencer.
package refclk_pkg;

    localparam int MAX_NCH = 16;
    localparam int SEL_W   = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // Lowest set bit wins, so channel 0 is always serviced first.
    function automatic logic [SEL_W-1:0] lowest_set_index(input logic [MAX_NCH-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = MAX_NCH - 1; i >= 0; i--) begin
            if (v[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/refclk_settle_cnt.sv
// Loadable settle down-counter; holds at zero and flags done there.
module refclk_settle_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt <= '0;
        else if (clr)           cnt <= '0;
        else if (load)          cnt <= load_val;
        else if (cnt != '0)     cnt <= cnt - CNT_W'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/refclk_obuf_seq.sv
// Staggered enable/disable sequencer for GT refclk output buffers (active-low CEB),
// one channel change per settle interval, with a global tristate override.
module refclk_obuf_seq
    import refclk_pkg::*;
#(
    parameter int             NCH           = 4,
    parameter int             SETTLE_CYCLES = 64,
    parameter int             CNT_W         = 16,
    parameter logic [NCH-1:0] EN_TX_PATH    = {NCH{1'b1}}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           gts,
    input  logic [NCH-1:0] en_req,
    output logic [NCH-1:0] ceb,
    output logic [NCH-1:0] ready,
    output logic           busy,
    output logic           err_cfg
);

    state_t           state_q, state_d;
    logic [NCH-1:0]   en_state_q, en_state_d;
    logic [NCH-1:0]   sel_q, sel_d;
    logic [NCH-1:0]   ceb_d, ready_d;
    logic [NCH-1:0]   tgt, diff, pick;
    logic [SEL_W-1:0] idx;
    logic             cnt_load, cnt_clr, cnt_done;

    assign tgt  = en_req & EN_TX_PATH & {NCH{~gts}};
    assign diff = tgt ^ en_state_q;
    assign idx  = lowest_set_index(MAX_NCH'(diff));

    always_comb begin
        pick = '0;
        for (int i = 0; i < NCH; i++) pick[i] = (SEL_W'(i) == idx);
    end

    always_comb begin
        state_d    = state_q;
        en_state_d = en_state_q;
        ceb_d      = ceb;
        ready_d    = ready;
        sel_d      = sel_q;
        cnt_load   = 1'b0;
        cnt_clr    = 1'b0;
        if (gts) begin
            // Tristate drops every channel at once, no sequencing.
            state_d    = IDLE;
            en_state_d = '0;
            ceb_d      = '1;
            ready_d    = '0;
            sel_d      = '0;
            cnt_clr    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (diff != '0) begin
                        en_state_d = en_state_q ^ pick;
                        ceb_d      = (ceb & ~pick) | (~tgt & pick);
                        ready_d    = ready & ~pick;
                        sel_d      = pick;
                        cnt_load   = 1'b1;
                        state_d    = SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_done) begin
                        ready_d = (ready & ~sel_q) | (en_state_q & sel_q);
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            en_state_q <= '0;
            sel_q      <= '0;
            ceb        <= '1;
            ready      <= '0;
        end else begin
            state_q    <= state_d;
            en_state_q <= en_state_d;
            sel_q      <= sel_d;
            ceb        <= ceb_d;
            ready      <= ready_d;
        end
    end

    refclk_settle_cnt #(.CNT_W(CNT_W)) u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .done     (cnt_done)
    );

    assign busy    = (state_q == SETTLE);
    assign err_cfg = |(en_req & ~EN_TX_PATH);

endmodule

// File: tb/tb_refclk_obuf_seq.sv
// Scoreboard bench: expected (cycle, ceb, ready) change events are queued as stimulus
// is applied and matched by a monitor that watches every output change.
module tb_refclk_obuf_seq;

    localparam int NCH = 4;
    localparam int SC  = 8;

    logic           clk = 1'b0;
    logic           rst, gts;
    logic [NCH-1:0] en_req;
    logic [NCH-1:0] ceb, ready, ceb2, ready2;
    logic           busy, err_cfg, busy2, err_cfg2;

    refclk_obuf_seq #(.NCH(NCH), .SETTLE_CYCLES(SC), .CNT_W(16), .EN_TX_PATH(4'b1111)) dut (
        .clk(clk), .rst(rst), .gts(gts), .en_req(en_req),
        .ceb(ceb), .ready(ready), .busy(busy), .err_cfg(err_cfg)
    );

    refclk_obuf_seq #(.NCH(NCH), .SETTLE_CYCLES(SC), .CNT_W(16), .EN_TX_PATH(4'b0111)) dut2 (
        .clk(clk), .rst(rst), .gts(gts), .en_req(en_req),
        .ceb(ceb2), .ready(ready2), .busy(busy2), .err_cfg(err_cfg2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        logic [3:0] ceb;
        logic [3:0] rdy;
    } ev_t;

    ev_t        sbq[$];
    int         cyc = 0;
    int         checks = 0;
    int         fails = 0;
    bit         mon_en = 0;
    logic [3:0] prev_ceb = 4'hF, prev_rdy = 4'h0;

    always @(posedge clk) cyc++;

    // Monitor: every output change must match the next queued expectation.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en && (ceb !== prev_ceb || ready !== prev_rdy)) begin
            checks++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected cyc=%0d ceb=%b ready=%b (no change expected)", cyc, ceb, ready);
            end else begin
                e = sbq.pop_front();
                if (e.cyc !== cyc || e.ceb !== ceb || e.rdy !== ready) begin
                    fails++;
                    $display("FAIL sb_event got cyc=%0d ceb=%b ready=%b expected cyc=%0d ceb=%b ready=%b",
                             cyc, ceb, ready, e.cyc, e.ceb, e.rdy);
                end
            end
        end
        prev_ceb = ceb;
        prev_rdy = ready;
    end

    task automatic push_ev(input int c, input logic [3:0] cb, input logic [3:0] rd);
        sbq.push_back('{c, cb, rd});
    endtask

    // Full sequential bring-up from all-off; first ceb edge one cycle after c.
    task automatic push_enable(input int c);
        logic [3:0] all1 = 4'hF;
        for (int k = 0; k < 4; k++) begin
            push_ev(c + 1 + 9*k, all1 << (k+1), ~(all1 << k));
            push_ev(c + 9 + 9*k, all1 << (k+1), ~(all1 << (k+1)));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; gts = 1'b0; en_req = 4'b0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        checks++; if (ceb !== 4'b1111) begin fails++; $display("FAIL reset_ceb got %b expected 1111", ceb); end
        checks++; if (ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b expected 0000", ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (err_cfg !== 1'b0) begin fails++; $display("FAIL reset_err_cfg got %b expected 0", err_cfg); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (ceb !== 4'b1111 || ready !== 4'b0000 || busy !== 1'b0) begin
            fails++; $display("FAIL idle_hold got ceb=%b ready=%b busy=%b expected 1111/0000/0", ceb, ready, busy);
        end
    endtask

    task automatic test_enable_all();
        int c = cyc;
        en_req = 4'b1111;
        push_enable(c);
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL enable_busy got %b expected 1", busy); end
        for (int i = 0; i < 100 && sbq.size() != 0; i++) begin @(negedge clk); #1; end
        checks++; if (sbq.size() != 0) begin fails++; $display("FAIL enable_timeout pending=%0d expected 0", sbq.size()); end
        @(posedge clk); #1;
        checks++; if (ready !== 4'b1111 || ceb !== 4'b0000 || busy !== 1'b0) begin
            fails++; $display("FAIL enable_final got ceb=%b ready=%b busy=%b expected 0000/1111/0", ceb, ready, busy);
        end
    endtask

    task automatic test_disable();
        int c = cyc;
        en_req = 4'b0101;
        push_ev(c + 1,  4'b0010, 4'b1101);
        push_ev(c + 10, 4'b1010, 4'b0101);
        for (int i = 0; i < 100 && sbq.size() != 0; i++) begin @(negedge clk); #1; end
        checks++; if (sbq.size() != 0) begin fails++; $display("FAIL disable_timeout pending=%0d expected 0", sbq.size()); end
        @(posedge clk); #1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || ceb !== 4'b1010 || ready !== 4'b0101) begin
            fails++; $display("FAIL disable_final got ceb=%b ready=%b busy=%b expected 1010/0101/0", ceb, ready, busy);
        end
    endtask

    task automatic test_gts();
        int c = cyc;
        en_req = 4'b1111;
        push_ev(c + 1, 4'b1000, 4'b0101);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL gts_pre_busy got %b expected 1", busy); end
        gts = 1'b1;
        push_ev(c + 5, 4'b1111, 4'b0000);
        @(posedge clk); #1;
        checks++; if (ceb !== 4'b1111 || ready !== 4'b0000 || busy !== 1'b0) begin
            fails++; $display("FAIL gts_force got ceb=%b ready=%b busy=%b expected 1111/0000/0", ceb, ready, busy);
        end
        repeat (2) @(posedge clk);
        #1 gts = 1'b0;
        push_enable(c + 7);
        for (int i = 0; i < 100 && sbq.size() != 0; i++) begin @(negedge clk); #1; end
        checks++; if (sbq.size() != 0) begin fails++; $display("FAIL gts_timeout pending=%0d expected 0", sbq.size()); end
        @(posedge clk); #1;
        checks++; if (ready !== 4'b1111 || busy !== 1'b0) begin
            fails++; $display("FAIL gts_final got ready=%b busy=%b expected 1111/0", ready, busy);
        end
    endtask

    task automatic test_tx_path();
        int r = cyc;
        bit bad3 = 1'b0;
        checks++; if (err_cfg2 !== 1'b1) begin fails++; $display("FAIL err_cfg_masked got %b expected 1", err_cfg2); end
        checks++; if (err_cfg !== 1'b0) begin fails++; $display("FAIL err_cfg_full got %b expected 0", err_cfg); end
        rst = 1'b1;
        push_ev(r, 4'b1111, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_enable(r + 2);
        for (int i = 0; i < 100 && sbq.size() != 0; i++) begin
            @(negedge clk); #1;
            if (ceb2[3] !== 1'b1) bad3 = 1'b1;
        end
        checks++; if (sbq.size() != 0) begin fails++; $display("FAIL txpath_timeout pending=%0d expected 0", sbq.size()); end
        @(posedge clk); #1;
        checks++; if (bad3) begin fails++; $display("FAIL txpath_ceb3_glitch got 0 expected 1"); end
        checks++; if (ceb2 !== 4'b1000 || ready2 !== 4'b0111 || busy2 !== 1'b0) begin
            fails++; $display("FAIL txpath_final got ceb=%b ready=%b busy=%b expected 1000/0111/0", ceb2, ready2, busy2);
        end
    endtask

    task automatic test_rst_mid_settle();
        int r = cyc;
        int c;
        rst = 1'b1;
        push_ev(r, 4'b1111, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        c = r + 2;
        push_ev(c + 1,  4'b1110, 4'b0000);
        push_ev(c + 9,  4'b1110, 4'b0001);
        push_ev(c + 10, 4'b1100, 4'b0001);
        push_ev(c + 18, 4'b1100, 4'b0011);
        push_ev(c + 19, 4'b1000, 4'b0011);
        repeat (22) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_mid_pre_busy got %b expected 1", busy); end
        rst = 1'b1;
        push_ev(c + 22, 4'b1111, 4'b0000);
        #1;
        checks++; if (ceb !== 4'b1111 || ready !== 4'b0000 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_mid_async got ceb=%b ready=%b busy=%b expected 1111/0000/0", ceb, ready, busy);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_enable(c + 24);
        for (int i = 0; i < 100 && sbq.size() != 0; i++) begin @(negedge clk); #1; end
        checks++; if (sbq.size() != 0) begin fails++; $display("FAIL rst_mid_timeout pending=%0d expected 0", sbq.size()); end
        @(posedge clk); #1;
        checks++; if (ready !== 4'b1111 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_mid_final got ready=%b busy=%b expected 1111/0", ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_enable_all();
        test_disable();
        test_gts();
        test_tx_path();
        test_rst_mid_settle();
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
